// File: rtl/microcode_sequencer_if.sv
// Interface between the microcode sequencer and its environment: the IR
// opcode, the control-decode feedback (RT), the front-panel controls, the
// asynchronous microcode ROM and the microinstruction handed to control
// decode.
interface microcode_sequencer_if #(
  parameter int OP_BITS = 8,
  parameter int T_BITS  = 3
);
  logic [OP_BITS-1:0]        opcode;
  logic                      rt;
  logic                      stall;
  logic                      run_mode;
  logic                      step_req;
  logic [OP_BITS+T_BITS-1:0] rom_addr;
  logic [15:0]               rom_data;
  logic [15:0]               uinstr;
  logic [T_BITS-1:0]         tstate;
  logic                      exec;
  logic                      instr_start;
  logic                      paused;

  // The sequencer itself.
  modport slave (
    input  opcode, rt, stall, run_mode, step_req, rom_data,
    output rom_addr, uinstr, tstate, exec, instr_start, paused
  );

  // The surrounding CPU, ROM and front panel.
  modport master (
    output opcode, rt, stall, run_mode, step_req, rom_data,
    input  rom_addr, uinstr, tstate, exec, instr_start, paused
  );
endinterface

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: forms the ROM address from {opcode, tstate}, passes
// the ROM word to control decode (or a NOP when nothing should execute),
// owns the T-state counter and implements free-run / single-instruction
// step control for the front panel.
module microcode_sequencer #(
  parameter int          T_BITS   = 3,
  parameter int          OP_BITS  = 8,
  parameter logic [15:0] NOP_WORD = 16'h8000
) (
  input logic                   clk,
  input logic                   reset,
  microcode_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    PAUSED,
    STEP
  } state_e;

  localparam logic [T_BITS-1:0] T_LAST = '1;

  state_e            state_q, state_d;
  logic [T_BITS-1:0] tstate_q, tstate_d;
  logic              exec;
  logic              instr_done;
  logic              idle_boundary;

  // A microinstruction executes only in RUN/STEP, not stalled, not in reset.
  // instr_done marks the exec cycle after which the next T-state is 0.
  always_comb begin
    exec          = ((state_q == RUN) || (state_q == STEP)) && !bus.stall && !reset;
    instr_done    = exec && (bus.rt || (tstate_q == T_LAST));
    idle_boundary = !exec && (tstate_q == '0);
  end

  // Next-state and next-T-state logic; a stalled cycle holds everything so
  // the deferred microinstruction is re-presented exactly once.
  always_comb begin
    // NOTE: every output of this block is given a default first so no
    // branch can leave it unassigned and infer a latch.
    state_d  = state_q;
    tstate_d = tstate_q;

    if (exec) begin
      tstate_d = instr_done ? '0 : tstate_q + 1'b1;
    end

    unique case (state_q)
      BOOT:   state_d = bus.run_mode ? RUN : PAUSED;
      RUN: begin
        if (!bus.run_mode && (instr_done || idle_boundary)) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (bus.run_mode) begin
          state_d = RUN;
        end else if (bus.step_req) begin
          state_d = STEP;
        end
      end
      STEP: begin
        // step_req is deliberately not looked at here.
        if (instr_done) begin
          state_d = bus.run_mode ? RUN : PAUSED;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // State and T-state registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q  <= BOOT;
      tstate_q <= '0;
    end else begin
      state_q  <= state_d;
      tstate_q <= tstate_d;
    end
  end

  // The ROM path is purely combinational; the opcode is used live.
  assign bus.rom_addr    = {bus.opcode, tstate_q};
  assign bus.uinstr      = exec ? bus.rom_data : NOP_WORD;
  assign bus.tstate      = tstate_q;
  assign bus.exec        = exec;
  assign bus.instr_start = exec && (tstate_q == '0);
  assign bus.paused      = (state_q == PAUSED) && !reset;

endmodule
